// File: rtl/comp_bist.sv
// Exhaustive self-test sequencer for a 4-bit magnitude comparator: sweeps every
// {A,B} pair, checks the one-hot Y result and reports error count and first failure.
module comp_bist #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic [3:0] A,
  output logic [3:0] B,
  input  logic [2:0] Y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [8:0] err_cnt,
  output logic [7:0] first_fail,
  output logic       fail_seen
);

  localparam int unsigned OP_W   = 4;
  localparam int unsigned IDX_W  = 2 * OP_W;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned ERR_W  = 9;
  localparam int unsigned RES_W  = 3;
  localparam int unsigned ERR_MAX = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic [CNT_W-1:0]   wcnt, wcnt_nxt;
  logic [OP_W-1:0]    a_nxt, b_nxt;
  logic               busy_nxt, done_nxt, pass_nxt;
  logic [ERR_W-1:0]   err_nxt, err_inc;
  logic [IDX_W-1:0]   ff_nxt;
  logic               fs_nxt;
  logic [RES_W-1:0]   exp_y;
  logic               sample, mismatch;

  // Reference result for the pair currently held on A/B
  always_comb begin
    exp_y = 3'b001;
    if (A > B) begin
      exp_y = 3'b100;
    end else if (A == B) begin
      exp_y = 3'b010;
    end
  end

  assign sample   = (wcnt == CNT_W'(SETTLE));
  assign mismatch = (Y != exp_y);
  // Saturating increment keeps the count from wrapping past a full sweep
  assign err_inc  = (err_cnt == ERR_W'(ERR_MAX)) ? err_cnt : err_cnt + ERR_W'(1);

  // Next-state and next-output logic
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    wcnt_nxt  = wcnt;
    a_nxt     = A;
    b_nxt     = B;
    busy_nxt  = busy;
    done_nxt  = done;
    pass_nxt  = pass;
    err_nxt   = err_cnt;
    ff_nxt    = first_fail;
    fs_nxt    = fail_seen;

    unique case (state)
      IDLE: begin
        if (start && !abort) begin
          state_nxt = RUN;
          idx_nxt   = '0;
          wcnt_nxt  = '0;
          a_nxt     = '0;
          b_nxt     = '0;
          busy_nxt  = 1'b1;
          done_nxt  = 1'b0;
          pass_nxt  = 1'b0;
          err_nxt   = '0;
          ff_nxt    = '0;
          fs_nxt    = 1'b0;
        end
      end

      RUN: begin
        if (abort) begin
          state_nxt = IDLE;
          idx_nxt   = '0;
          wcnt_nxt  = '0;
          a_nxt     = '0;
          b_nxt     = '0;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b0;
        end else if (sample) begin
          if (mismatch) begin
            err_nxt = err_inc;
            if (!fail_seen) begin
              ff_nxt = {A, B};
              fs_nxt = 1'b1;
            end
          end
          wcnt_nxt = '0;
          if (idx == IDX_W'(8'hFF)) begin
            state_nxt = DONE;
            idx_nxt   = '0;
            a_nxt     = '0;
            b_nxt     = '0;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            pass_nxt  = (err_nxt == '0);
          end else begin
            idx_nxt = idx + IDX_W'(1);
            a_nxt   = idx_nxt[IDX_W-1:OP_W];
            b_nxt   = idx_nxt[OP_W-1:0];
          end
        end else begin
          wcnt_nxt = wcnt + CNT_W'(1);
        end
      end

      DONE: begin
        if (abort) begin
          state_nxt = IDLE;
          idx_nxt   = '0;
          wcnt_nxt  = '0;
          a_nxt     = '0;
          b_nxt     = '0;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b0;
        end else if (start) begin
          state_nxt = RUN;
          idx_nxt   = '0;
          wcnt_nxt  = '0;
          a_nxt     = '0;
          b_nxt     = '0;
          busy_nxt  = 1'b1;
          done_nxt  = 1'b0;
          pass_nxt  = 1'b0;
          err_nxt   = '0;
          ff_nxt    = '0;
          fs_nxt    = 1'b0;
        end
      end

      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
        wcnt_nxt  = '0;
        a_nxt     = '0;
        b_nxt     = '0;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      wcnt       <= '0;
      A          <= '0;
      B          <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= '0;
      first_fail <= '0;
      fail_seen  <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      wcnt       <= wcnt_nxt;
      A          <= a_nxt;
      B          <= b_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      pass       <= pass_nxt;
      err_cnt    <= err_nxt;
      first_fail <= ff_nxt;
      fail_seen  <= fs_nxt;
    end
  end

endmodule
